// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-array arbiter.
package regfile_arb_pkg;

   // Sequencer states for the array owner.
   typedef enum logic [1:0] {
      INIT  = 2'd0,
      IDLE  = 2'd1,
      SWEEP = 2'd2
   } state_t;

   // Round-robin pointer values: which requester wins the next tie.
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. gnt[0] is requester A, gnt[1] is requester B.
module rr_arb2
   import regfile_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic ptr_q;

   // One-hot grant: a lone request always wins, a tie goes to the pointer side.
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr_q == SEL_A) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Pointer moves away from whichever side was just served.
   always_ff @(posedge clk) begin
      if (reset)
         ptr_q <= SEL_A;
      else if (gnt[0])
         ptr_q <= SEL_B;
      else if (gnt[1])
         ptr_q <= SEL_A;
   end

endmodule

// File: rtl/regfile_arbiter.sv
// Register array shared by two requesters, with post-reset init and a
// whole-array increment sweep.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   INIT  | writing mem[cnt] = cnt, one word per cycle, after reset
//   IDLE  | serving A/B accesses through the round-robin arbiter
//   SWEEP | mem[cnt] += 1 one word per cycle; all requests stall
module regfile_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8,
   parameter int ABITS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_req,
   input  logic             a_we,
   input  logic [ABITS-1:0] a_addr,
   input  logic [WIDTH-1:0] a_wdata,
   output logic             a_gnt,
   output logic             a_rvalid,
   input  logic             b_req,
   input  logic             b_we,
   input  logic [ABITS-1:0] b_addr,
   input  logic [WIDTH-1:0] b_wdata,
   output logic             b_gnt,
   output logic             b_rvalid,
   output logic [WIDTH-1:0] rdata,
   input  logic             inc_all,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [ABITS-1:0] cnt_q;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             arb_en, init_we, sweep_we, cnt_last;
   logic [1:0]       gnt;
   logic             sel_we, sel_in_range;
   logic [ABITS-1:0] sel_addr;
   logic [WIDTH-1:0] sel_wdata;
   logic             rv_a_q, rv_b_q;
   logic [WIDTH-1:0] rdata_q;

   assign cnt_last = (cnt_q == ABITS'(DEPTH - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= INIT;
      else
         state_q <= state_d;
   end

   // Next state: INIT and SWEEP each walk the array once; inc_all wins in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT:    if (cnt_last) state_d = IDLE;
         IDLE:    if (inc_all)  state_d = SWEEP;
         SWEEP:   if (cnt_last) state_d = IDLE;
         default: state_d = INIT;
      endcase
   end

   // FSM outputs; reset forces the busy/no-grant view combinationally.
   always_comb begin
      busy     = 1'b1;
      arb_en   = 1'b0;
      init_we  = 1'b0;
      sweep_we = 1'b0;
      if (!reset) begin
         case (state_q)
            INIT:    init_we = 1'b1;
            IDLE: begin
               busy   = 1'b0;
               arb_en = !inc_all;
            end
            SWEEP:   sweep_we = 1'b1;
            default: busy = 1'b1;
         endcase
      end
   end

   // Word counter for INIT and SWEEP; parked at zero otherwise.
   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else if ((init_we || sweep_we) && !cnt_last)
         cnt_q <= cnt_q + 1'b1;
      else
         cnt_q <= '0;
   end

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .en    (arb_en),
      .req   ({b_req, a_req}),
      .gnt   (gnt)
   );

   // Route the granted requester's access fields to the array.
   always_comb begin
      sel_we       = gnt[1] ? b_we    : a_we;
      sel_addr     = gnt[1] ? b_addr  : a_addr;
      sel_wdata    = gnt[1] ? b_wdata : a_wdata;
      sel_in_range = (int'(sel_addr) < DEPTH);
   end

   // Array writes: sequencer has the port in INIT/SWEEP, clients in IDLE.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (init_we)
            mem[cnt_q] <= WIDTH'(cnt_q);
         else if (sweep_we)
            mem[cnt_q] <= mem[cnt_q] + 1'b1;
         else if ((|gnt) && sel_we && sel_in_range)
            mem[sel_addr] <= sel_wdata;
      end
   end

   // Read register: one-cycle latency, holds until the next read.
   always_ff @(posedge clk) begin
      if (reset) begin
         rv_a_q  <= 1'b0;
         rv_b_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         rv_a_q <= gnt[0] && !sel_we;
         rv_b_q <= gnt[1] && !sel_we;
         if ((|gnt) && !sel_we)
            rdata_q <= sel_in_range ? mem[sel_addr] : '0;
      end
   end

   assign a_gnt    = gnt[0];
   assign b_gnt    = gnt[1];
   assign a_rvalid = rv_a_q && !reset;
   assign b_rvalid = rv_b_q && !reset;
   assign rdata    = reset ? '0 : rdata_q;

endmodule
